// File: rtl/cordic_engine.sv
// cordic_engine: iterative multi-mode CORDIC, one micro-rotation per clock on signed Q16.16 operands
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              start strobe, sampled only while idle
//   mode_op             0 rotation (drive z->0), 1 vectoring (drive y->0)
//   mode_coord          01 circular, 11 hyperbolic, 00/10 linear
//   x_in, y_in, z_in    operands, latched on the starting edge
//   x_out, y_out, z_out registered results, held until the next completion
//   valid               one-cycle completion pulse
// Build option CORDIC_GAIN_COMP_EN: scale x/y by 1/K (circular) or 1/Kh (hyperbolic) at completion.
module cordic_engine #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode_op,
    input  logic [1:0]              mode_coord,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    valid
);
    localparam int CW = $clog2(ITERATIONS + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic signed [WIDTH-1:0] r_x, r_y, r_z;
    logic signed [WIDTH-1:0] w_xs, w_ys, w_e, w_xn, w_yn, w_zn, w_xo, w_yo;
    logic                    r_op;
    logic [1:0]              r_coord;
    logic                    w_circ, w_hyp, w_pos;
    int                      w_k, w_sh;

    // Rounded Q16.16 angle constants; beyond the listed entries every table equals 2^-i.
    function automatic logic signed [WIDTH-1:0] rom(input logic [1:0] c, input int i);
        logic [31:0] v;
        v = 32'd65536 >> i;
        if (c == 2'b01)
            case (i)
                0: v = 32'd51472;
                1: v = 32'd30386;
                2: v = 32'd16055;
                3: v = 32'd8150;
                4: v = 32'd4091;
                5: v = 32'd2047;
                default: ;
            endcase
        else if (c == 2'b11)
            case (i)
                1: v = 32'd35999;
                2: v = 32'd16739;
                3: v = 32'd8235;
                4: v = 32'd4101;
                5: v = 32'd2049;
                default: ;
            endcase
        return WIDTH'(v);
    endfunction

    always_comb begin
        w_circ = r_coord == 2'b01;
        w_hyp  = r_coord == 2'b11;
        w_k    = int'(r_cnt);
        // hyperbolic indices start at 1 and repeat 4 and 13 so the series still converges
        w_sh   = w_hyp ? w_k + 1 - (w_k >= 4 ? 1 : 0) - (w_k >= 14 ? 1 : 0) : w_k;
        // w_pos is d = +1
        w_pos  = r_op ? r_y[WIDTH-1] : ~r_z[WIDTH-1];
        w_xs   = r_x >>> w_sh;
        w_ys   = r_y >>> w_sh;
        w_e    = rom(r_coord, w_sh);
        w_xn   = w_circ ? (w_pos ? r_x - w_ys : r_x + w_ys) :
                 w_hyp  ? (w_pos ? r_x + w_ys : r_x - w_ys) : r_x;
        w_yn   = w_pos ? r_y + w_xs : r_y - w_xs;
        w_zn   = w_pos ? r_z - w_e : r_z + w_e;
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [WIDTH-1:0]   w_g;
    logic signed [2*WIDTH-1:0] w_px, w_py;
    assign w_g  = w_circ ? WIDTH'(32'sh0000_9B75) : WIDTH'(32'sh0001_351E);
    assign w_px = (2*WIDTH)'(r_x) * (2*WIDTH)'(w_g);
    assign w_py = (2*WIDTH)'(r_y) * (2*WIDTH)'(w_g);
    assign w_xo = (w_circ || w_hyp) ? w_px[WIDTH+15:16] : r_x;
    assign w_yo = (w_circ || w_hyp) ? w_py[WIDTH+15:16] : r_y;
`else
    assign w_xo = r_x;
    assign w_yo = r_y;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = enable ? S_RUN : S_IDLE;
            S_RUN:   w_next = (r_cnt == CW'(ITERATIONS - 1)) ? S_DONE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_op    <= 1'b0;
            r_coord <= '0;
            r_cnt   <= '0;
            x_out   <= '0;
            y_out   <= '0;
            z_out   <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (r_state == S_IDLE && enable) begin
                r_x     <= x_in;
                r_y     <= y_in;
                r_z     <= z_in;
                r_op    <= mode_op;
                r_coord <= mode_coord;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_x   <= w_xn;
                r_y   <= w_yn;
                r_z   <= w_zn;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_DONE) begin
                x_out <= w_xo;
                y_out <= w_yo;
                z_out <= r_z;
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: spec vectors, corner sequences and random operations against a reference model
module tb_cordic_engine;
    localparam int W   = 32;
    localparam int N   = 16;
    localparam int TOL = 131;

    logic                clk = 1'b0, rst = 1'b1, enable = 1'b0, mode_op = 1'b0;
    logic [1:0]          mode_coord = 2'b00;
    logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic signed [W-1:0] x_out, y_out, z_out;
    logic                valid;
    int                  checks = 0, errors = 0;
    int                  hseq[$];
    real                 kc, kh, gc, gh;

    typedef struct packed {
        logic [1:0]         coord;
        logic               op;
        logic signed [31:0] x, y, z, ex, ey, ez;
    } vec_t;
    vec_t vt[7];

    cordic_engine #(.WIDTH(W), .ITERATIONS(N)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode_op(mode_op), .mode_coord(mode_coord),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic int q(input real r);
        return int'(r * 65536.0);
    endfunction

    function automatic real p2(input int i);
        real p = 1.0;
        repeat (i) p = p / 2.0;
        return p;
    endfunction

    function automatic int rnd(input int lim);
        return int'($urandom_range(2 * lim)) - lim;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp, input int tol);
        longint diff;
        checks++;
        diff = longint'(act) - longint'(exp);
        if (diff < 0) diff = -diff;
        if (diff > longint'(tol)) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d (0x%08h) want %0d (0x%08h) tol %0d", nm, idx, act, act, exp, exp, tol);
        end
    endtask

    // Direct application of the micro-rotation equations over the spec's index sequence.
    function automatic void model(input logic [1:0] c, input logic o, input int x0, input int y0, input int z0,
                                  output int rx, output int ry, output int rz);
        int x = x0, y = y0, z = z0, m, i, d, xn, e;
        m = (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
        for (int k = 0; k < N; k++) begin
            i  = (c == 2'b11) ? hseq[k] : k;
            d  = o ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
            e  = (c == 2'b01) ? q($atan(p2(i))) : (c == 2'b11) ? q($atanh(p2(i))) : q(p2(i));
            xn = x - m * d * (y >>> i);
            y  = y + d * (x >>> i);
            z  = z - d * e;
            x  = xn;
        end
`ifdef CORDIC_GAIN_COMP_EN
        if (c == 2'b01 || c == 2'b11) begin
            longint g;
            g = (c == 2'b01) ? 64'h9B75 : 64'h1351E;
            x = int'((longint'(x) * g) >>> 16);
            y = int'((longint'(y) * g) >>> 16);
        end
`endif
        rx = x;
        ry = y;
        rz = z;
    endfunction

    // Starts one operation, scrambles the inputs right after the start edge, waits for valid.
    task automatic run_op(input logic [1:0] c, input logic o, input int x, input int y, input int z,
                          output int rx, output int ry, output int rz, output int lat);
        @(negedge clk);
        mode_coord = c; mode_op = o; x_in = x; y_in = y; z_in = z; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; mode_coord = ~c; mode_op = ~o;
        x_in = $urandom; y_in = $urandom; z_in = $urandom;
        lat = -1;
        for (int k = 1; k <= N + 8 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (valid) lat = k;
        end
        rx = x_out; ry = y_out; rz = z_out;
    endtask

    initial begin
        int rx, ry, rz, lat, ex, ey, ez, pulses;
        logic [1:0] c;
        logic o;
        int x, y, z;

        for (int i = 1; hseq.size() < N; i++) begin
            hseq.push_back(i);
            if ((i == 4 || i == 13) && hseq.size() < N) hseq.push_back(i);
        end
        kc = 1.0;
        kh = 1.0;
        for (int i = 0; i < N; i++) kc = kc * $sqrt(1.0 + p2(i) * p2(i));
        foreach (hseq[j]) kh = kh * $sqrt(1.0 - p2(hseq[j]) * p2(hseq[j]));
`ifdef CORDIC_GAIN_COMP_EN
        gc = 1.0;
        gh = 1.0;
`else
        gc = kc;
        gh = kh;
`endif
        vt[0] = '{2'b00, 1'b0, q(5.0), 0, q(1.5), q(5.0), q(7.5), 0};
        vt[1] = '{2'b00, 1'b1, q(4.0), q(6.0), 0, q(4.0), 0, q(1.5)};
        vt[2] = '{2'b01, 1'b0, q(1.0), 0, 32'sh0000C90F, q(gc * 0.707107), q(gc * 0.707107), 0};
        vt[3] = '{2'b01, 1'b1, q(3.0), q(4.0), 0, q(gc * 5.0), 0, q(0.927295)};
        vt[4] = '{2'b11, 1'b0, q(1.0), 0, q(0.5), q(gh * 1.127626), q(gh * 0.521095), 0};
        vt[5] = '{2'b10, 1'b0, q(2.0), q(1.0), q(-0.75), q(2.0), q(-0.5), 0};
        vt[6] = '{2'b11, 1'b1, q(1.2), q(0.4), 0, q(gh * 1.131371), 0, q(0.346574)};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 0, int'(valid), 0, 0);
        chk("rst_x", 0, x_out, 0, 0);
        chk("rst_y", 0, y_out, 0, 0);
        chk("rst_z", 0, z_out, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_op(vt[t].coord, vt[t].op, vt[t].x, vt[t].y, vt[t].z, rx, ry, rz, lat);
            chk("vec_lat", t, lat, N + 1, 0);
            chk("vec_x", t, rx, vt[t].ex, TOL);
            chk("vec_y", t, ry, vt[t].ey, TOL);
            chk("vec_z", t, rz, vt[t].ez, TOL);
            @(posedge clk); #1;
            chk("vec_pulse_end", t, int'(valid), 0, 0);
            chk("vec_hold_x", t, x_out, rx, 0);
        end

        // reset in the middle of an operation aborts it without a valid
        @(negedge clk);
        mode_coord = 2'b01; mode_op = 1'b0; x_in = q(1.0); y_in = 0; z_in = q(0.3); enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_x", 0, x_out, 0, 0);
        chk("midrst_y", 0, y_out, 0, 0);
        chk("midrst_z", 0, z_out, 0, 0);
        chk("midrst_valid", 0, int'(valid), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (N + 6) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        chk("midrst_no_valid", 0, pulses, 0, 0);

        // enable during RUN and during the DONE cycle are both ignored
        model(2'b01, 1'b0, q(1.0), 0, q(0.5), ex, ey, ez);
        pulses = 0;
        lat = -1;
        for (int k = 0; k <= 2 * N + 8; k++) begin
            @(negedge clk);
            enable = (k == 0 || k == 4 || k == N + 1);
            mode_coord = (k == 0) ? 2'b01 : 2'b00;
            mode_op = 1'b0;
            x_in = (k == 0) ? q(1.0) : q(2.0);
            y_in = (k == 0) ? 0 : q(1.0);
            z_in = (k == 0) ? q(0.5) : q(-1.0);
            @(posedge clk); #1;
            if (valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    rx = x_out; ry = y_out; rz = z_out;
                end
            end
        end
        enable = 1'b0;
        chk("busy_pulses", 0, pulses, 1, 0);
        chk("busy_lat", 0, lat, N + 1, 0);
        chk("busy_x", 0, rx, ex, 0);
        chk("busy_y", 0, ry, ey, 0);
        chk("busy_z", 0, rz, ez, 0);

        for (int t = 0; t < 30; t++) begin
            c = 2'($urandom_range(3));
            o = 1'($urandom_range(1));
            x = rnd(3 << 16);
            y = rnd(3 << 16);
            z = rnd(1 << 17);
            model(c, o, x, y, z, ex, ey, ez);
            run_op(c, o, x, y, z, rx, ry, rz, lat);
            chk("rnd_lat", t, lat, N + 1, 0);
            chk("rnd_x", t, rx, ex, 0);
            chk("rnd_y", t, ry, ey, 0);
            chk("rnd_z", t, rz, ez, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
